// File: rtl/sramlike_axi_bridge_pkg.sv
// sramlike_axi_bridge_pkg: shared state encoding, AXI constants and write-strobe helper
package sramlike_axi_bridge_pkg;
  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AW_W, WR_B} state_t;
  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;
  localparam logic [1:0] BURST_INCR = 2'b01;
  function automatic logic [3:0] size_to_wstrb(input logic [1:0] size, input logic [1:0] off);
    return size == 2'b00 ? 4'b0001 << off : size == 2'b01 ? 4'b0011 << off : 4'b1111;
  endfunction
endpackage

// File: rtl/sramlike_axi_bridge_if.sv
// sramlike_axi_bridge_if: AXI3 single-master bus between the bridge and the interconnect
interface sramlike_axi_bridge_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic [3:0] arid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst, arlock;
  logic [3:0] arcache;
  logic [2:0] arprot;
  logic arvalid, arready;
  logic [3:0] rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0] rresp;
  logic rlast, rvalid, rready;
  logic [3:0] awid;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst, awlock;
  logic [3:0] awcache;
  logic [2:0] awprot;
  logic awvalid, awready;
  logic [3:0] wid;
  logic [DATA_W-1:0] wdata;
  logic [3:0] wstrb;
  logic wlast, wvalid, wready;
  logic [3:0] bid;
  logic [1:0] bresp;
  logic bvalid, bready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input arready, rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input wready, bid, bresp, bvalid,
    output bready
  );
  modport slave (
    input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready, rid, rdata, rresp, rlast, rvalid,
    input rready,
    input awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input wid, wdata, wstrb, wlast, wvalid,
    output wready, bid, bresp, bvalid,
    input bready
  );
endinterface

// File: rtl/sramlike_axi_bridge.sv
// sramlike_axi_bridge: turns sram-like inst/data requests into single-beat AXI3 transfers, data first
module sramlike_axi_bridge
  import sramlike_axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  sramlike_axi_bridge_if.master axi
);
  state_t state;
  logic src;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0] size_q;
  logic [DATA_W-1:0] wdata_q, inst_rdata_q, data_rdata_q;
  logic aw_done, w_done, rd_ok, done, unused;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      src <= 1'b0;
      addr_q <= '0;
      size_q <= '0;
      wdata_q <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (data_req || inst_req) begin
          src <= data_req;
          addr_q <= data_req ? data_addr : inst_addr;
          size_q <= data_req ? data_size : inst_size;
          wdata_q <= data_wdata;
          state <= (data_req ? data_wr : inst_wr) ? WR_AW_W : RD_AR;
        end
        RD_AR: if (axi.arready) state <= RD_R;
        RD_R: if (axi.rvalid) begin
          if (src) data_rdata_q <= axi.rdata;
          else inst_rdata_q <= axi.rdata;
          state <= IDLE;
        end
        WR_AW_W: begin
          aw_done <= aw_done | axi.awready;
          w_done <= w_done | axi.wready;
          if ((aw_done | axi.awready) && (w_done | axi.wready)) begin
            aw_done <= 1'b0;
            w_done <= 1'b0;
            state <= WR_B;
          end
        end
        WR_B: if (axi.bvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign data_addr_ok = state == IDLE && data_req;
  assign inst_addr_ok = state == IDLE && inst_req && !data_req;
  assign rd_ok = state == RD_R && axi.rvalid;
  assign done = rd_ok || (state == WR_B && axi.bvalid);
  assign data_data_ok = done && src;
  assign inst_data_ok = done && !src;
  // read data bypasses the register on the return cycle so data_ok needs no extra beat
  assign data_rdata = rd_ok && src ? axi.rdata : data_rdata_q;
  assign inst_rdata = rd_ok && !src ? axi.rdata : inst_rdata_q;
  assign axi.arid = src ? ID_DATA : ID_INST;
  assign axi.araddr = addr_q;
  assign axi.arlen = 4'd0;
  assign axi.arsize = {1'b0, size_q};
  assign axi.arburst = BURST_INCR;
  assign axi.arlock = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot = 3'd0;
  assign axi.arvalid = state == RD_AR;
  assign axi.rready = state == RD_R;
  assign axi.awid = ID_DATA;
  assign axi.awaddr = addr_q;
  assign axi.awlen = 4'd0;
  assign axi.awsize = {1'b0, size_q};
  assign axi.awburst = BURST_INCR;
  assign axi.awlock = 2'b00;
  assign axi.awcache = 4'd0;
  assign axi.awprot = 3'd0;
  assign axi.awvalid = state == WR_AW_W && !aw_done;
  assign axi.wid = ID_DATA;
  assign axi.wdata = wdata_q;
  assign axi.wstrb = size_to_wstrb(size_q, addr_q[1:0]);
  assign axi.wlast = 1'b1;
  assign axi.wvalid = state == WR_AW_W && !w_done;
  assign axi.bready = state == WR_B;
  assign unused = ^{inst_wdata, axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};
endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// tb_sramlike_axi_bridge: directed scenario checks of the sram-like to AXI bridge
module tb_sramlike_axi_bridge;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0;
  logic [1:0] inst_size = 2'b10, data_size = 2'b10;
  logic [31:0] inst_addr = 0, inst_wdata = 0, data_addr = 0, data_wdata = 0;
  logic [31:0] inst_rdata, data_rdata;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  int checks = 0, errors = 0, aw_hs = 0, w_hs = 0;
  sramlike_axi_bridge_if axi();
  sramlike_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .axi(axi.master)
  );
  always @(posedge clk) begin
    if (axi.awvalid && axi.awready) aw_hs++;
    if (axi.wvalid && axi.wready) w_hs++;
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1;
    step;
    step;
    checks++; if (axi.arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b want 0", axi.arvalid); end
    checks++; if (axi.awvalid !== 1'b0) begin errors++; $display("FAIL reset_awvalid: got %b want 0", axi.awvalid); end
    checks++; if (axi.wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid: got %b want 0", axi.wvalid); end
    checks++; if (axi.rready !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b want 0", axi.rready); end
    checks++; if (axi.bready !== 1'b0) begin errors++; $display("FAIL reset_bready: got %b want 0", axi.bready); end
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL reset_data_ok: got %b want 00", {inst_data_ok, data_data_ok}); end
    checks++; if (inst_rdata !== 32'h0) begin errors++; $display("FAIL reset_inst_rdata: got %h want 0", inst_rdata); end
    checks++; if (data_rdata !== 32'h0) begin errors++; $display("FAIL reset_data_rdata: got %h want 0", data_rdata); end
    checks++; if (axi.arid !== 4'd0) begin errors++; $display("FAIL reset_arid: got %h want 0", axi.arid); end
    checks++; if ({axi.arlen, axi.arburst, axi.awburst} !== 8'b0000_01_01) begin errors++; $display("FAIL tied_len_burst: got %b want 00000101", {axi.arlen, axi.arburst, axi.awburst}); end
    rst = 0;
    step;
  endtask
  task automatic test_inst_read;
    inst_req = 1; inst_addr = 32'hBFC00000; inst_size = 2'b10;
    #1;
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin errors++; $display("FAIL ir_addr_ok: got %b want 10", {inst_addr_ok, data_addr_ok}); end
    step;
    inst_req = 0;
    #1;
    checks++; if (inst_addr_ok !== 1'b0) begin errors++; $display("FAIL ir_addr_ok_pulse: got %b want 0", inst_addr_ok); end
    checks++; if (axi.arvalid !== 1'b1) begin errors++; $display("FAIL ir_arvalid: got %b want 1", axi.arvalid); end
    checks++; if (axi.araddr !== 32'hBFC00000) begin errors++; $display("FAIL ir_araddr: got %h want bfc00000", axi.araddr); end
    checks++; if (axi.arid !== 4'd0) begin errors++; $display("FAIL ir_arid: got %h want 0", axi.arid); end
    checks++; if (axi.arsize !== 3'b010) begin errors++; $display("FAIL ir_arsize: got %b want 010", axi.arsize); end
    step;
    checks++; if (axi.arvalid !== 1'b1) begin errors++; $display("FAIL ir_arvalid_hold: got %b want 1", axi.arvalid); end
    axi.arready = 1;
    step;
    axi.arready = 0;
    #1;
    checks++; if ({axi.rready, axi.arvalid, inst_data_ok} !== 3'b100) begin errors++; $display("FAIL ir_rstate: got %b want 100", {axi.rready, axi.arvalid, inst_data_ok}); end
    axi.rdata = 32'h3C08BFAF; axi.rvalid = 1;
    #1;
    checks++; if (inst_data_ok !== 1'b1) begin errors++; $display("FAIL ir_data_ok: got %b want 1", inst_data_ok); end
    checks++; if (inst_rdata !== 32'h3C08BFAF) begin errors++; $display("FAIL ir_rdata_bypass: got %h want 3c08bfaf", inst_rdata); end
    checks++; if (data_data_ok !== 1'b0) begin errors++; $display("FAIL ir_wrong_src_ok: got %b want 0", data_data_ok); end
    step;
    axi.rvalid = 0; axi.rdata = 32'h0;
    #1;
    checks++; if ({inst_data_ok, axi.rready} !== 2'b00) begin errors++; $display("FAIL ir_after: got %b want 00", {inst_data_ok, axi.rready}); end
    checks++; if (inst_rdata !== 32'h3C08BFAF) begin errors++; $display("FAIL ir_rdata_reg: got %h want 3c08bfaf", inst_rdata); end
  endtask
  task automatic test_byte_store;
    data_req = 1; data_wr = 1; data_size = 2'b00; data_addr = 32'h80001003; data_wdata = 32'hAB000000;
    #1;
    checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL bs_addr_ok: got %b want 1", data_addr_ok); end
    step;
    data_req = 0;
    #1;
    checks++; if ({axi.awvalid, axi.wvalid, axi.wlast} !== 3'b111) begin errors++; $display("FAIL bs_valids: got %b want 111", {axi.awvalid, axi.wvalid, axi.wlast}); end
    checks++; if (axi.awaddr !== 32'h80001003) begin errors++; $display("FAIL bs_awaddr: got %h want 80001003", axi.awaddr); end
    checks++; if (axi.wstrb !== 4'b1000) begin errors++; $display("FAIL bs_wstrb: got %b want 1000", axi.wstrb); end
    checks++; if (axi.awsize !== 3'b000) begin errors++; $display("FAIL bs_awsize: got %b want 000", axi.awsize); end
    checks++; if (axi.wdata !== 32'hAB000000) begin errors++; $display("FAIL bs_wdata: got %h want ab000000", axi.wdata); end
    checks++; if ({axi.awid, axi.wid} !== 8'h11) begin errors++; $display("FAIL bs_ids: got %h want 11", {axi.awid, axi.wid}); end
    aw_hs = 0; w_hs = 0;
    axi.awready = 1; axi.wready = 1;
    step;
    axi.awready = 0; axi.wready = 0;
    #1;
    checks++; if ({aw_hs[1:0], w_hs[1:0]} !== 4'b0101) begin errors++; $display("FAIL bs_handshakes: got aw=%0d w=%0d want 1 1", aw_hs, w_hs); end
    checks++; if ({axi.bready, axi.awvalid, axi.wvalid, data_data_ok} !== 4'b1000) begin errors++; $display("FAIL bs_wr_b: got %b want 1000", {axi.bready, axi.awvalid, axi.wvalid, data_data_ok}); end
    step;
    checks++; if ({axi.bready, data_data_ok} !== 2'b10) begin errors++; $display("FAIL bs_wait_b: got %b want 10", {axi.bready, data_data_ok}); end
    axi.bvalid = 1;
    #1;
    checks++; if ({data_data_ok, inst_data_ok} !== 2'b10) begin errors++; $display("FAIL bs_data_ok: got %b want 10", {data_data_ok, inst_data_ok}); end
    step;
    axi.bvalid = 0;
    #1;
    checks++; if ({axi.bready, data_data_ok} !== 2'b00) begin errors++; $display("FAIL bs_after: got %b want 00", {axi.bready, data_data_ok}); end
  endtask
  task automatic test_simultaneous;
    inst_req = 1; inst_addr = 32'hBFC00004; inst_size = 2'b10;
    data_req = 1; data_wr = 0; data_size = 2'b10; data_addr = 32'h80002000;
    #1;
    checks++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin errors++; $display("FAIL sim_priority: got %b want 10", {data_addr_ok, inst_addr_ok}); end
    step;
    data_req = 0;
    #1;
    checks++; if (inst_addr_ok !== 1'b0) begin errors++; $display("FAIL sim_busy_ar: got %b want 0", inst_addr_ok); end
    checks++; if ({axi.araddr, axi.arid} !== {32'h80002000, 4'd1}) begin errors++; $display("FAIL sim_ar: got %h/%h want 80002000/1", axi.araddr, axi.arid); end
    axi.arready = 1;
    step;
    axi.arready = 0;
    #1;
    checks++; if (inst_addr_ok !== 1'b0) begin errors++; $display("FAIL sim_busy_r: got %b want 0", inst_addr_ok); end
    axi.rdata = 32'h12345678; axi.rvalid = 1;
    #1;
    checks++; if ({data_data_ok, inst_data_ok} !== 2'b10) begin errors++; $display("FAIL sim_data_ok: got %b want 10", {data_data_ok, inst_data_ok}); end
    checks++; if (data_rdata !== 32'h12345678) begin errors++; $display("FAIL sim_rdata: got %h want 12345678", data_rdata); end
    step;
    axi.rvalid = 0; axi.rdata = 32'h0;
    #1;
    checks++; if ({inst_addr_ok, data_data_ok} !== 2'b10) begin errors++; $display("FAIL sim_inst_accept: got %b want 10", {inst_addr_ok, data_data_ok}); end
    checks++; if ({data_rdata, inst_rdata} !== {32'h12345678, 32'h3C08BFAF}) begin errors++; $display("FAIL sim_rdata_regs: got %h %h want 12345678 3c08bfaf", data_rdata, inst_rdata); end
    step;
    inst_req = 0;
    #1;
    checks++; if ({axi.arvalid, axi.araddr, axi.arid} !== {1'b1, 32'hBFC00004, 4'd0}) begin errors++; $display("FAIL sim_inst_ar: got %b %h %h want 1 bfc00004 0", axi.arvalid, axi.araddr, axi.arid); end
    axi.arready = 1;
    step;
    axi.arready = 0; axi.rdata = 32'h00000001; axi.rvalid = 1;
    #1;
    checks++; if ({inst_data_ok, inst_rdata} !== {1'b1, 32'h00000001}) begin errors++; $display("FAIL sim_inst_data: got %b %h want 1 00000001", inst_data_ok, inst_rdata); end
    step;
    axi.rvalid = 0;
  endtask
  task automatic test_write_order;
    data_req = 1; data_wr = 1; data_size = 2'b10; data_addr = 32'h80003000; data_wdata = 32'hDEADBEEF;
    step;
    data_req = 0; aw_hs = 0; w_hs = 0; axi.wready = 1;
    #1;
    checks++; if ({axi.wstrb, axi.awsize} !== 7'b1111_010) begin errors++; $display("FAIL wo_strb_size: got %b %b want 1111 010", axi.wstrb, axi.awsize); end
    for (int i = 0; i < 3; i++) begin
      step;
      checks++; if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b100) begin errors++; $display("FAIL wo_wait_aw%0d: got %b want 100", i, {axi.awvalid, axi.wvalid, axi.bready}); end
    end
    axi.awready = 1;
    step;
    axi.awready = 0; axi.wready = 0;
    #1;
    checks++; if ({aw_hs[1:0], w_hs[1:0]} !== 4'b0101) begin errors++; $display("FAIL wo_handshakes: got aw=%0d w=%0d want 1 1", aw_hs, w_hs); end
    checks++; if (axi.bready !== 1'b1) begin errors++; $display("FAIL wo_wr_b: got %b want 1", axi.bready); end
    axi.bvalid = 1;
    step;
    axi.bvalid = 0;
  endtask
  task automatic test_half_store;
    data_req = 1; data_wr = 1; data_size = 2'b01; data_addr = 32'h80000002; data_wdata = 32'h5A5A0000;
    step;
    data_req = 0;
    #1;
    checks++; if (axi.wstrb !== 4'b1100) begin errors++; $display("FAIL hs_wstrb: got %b want 1100", axi.wstrb); end
    checks++; if (axi.awsize !== 3'b001) begin errors++; $display("FAIL hs_awsize: got %b want 001", axi.awsize); end
    axi.awready = 1; axi.wready = 1;
    step;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 1;
    #1;
    checks++; if (data_data_ok !== 1'b1) begin errors++; $display("FAIL hs_data_ok: got %b want 1", data_data_ok); end
    step;
    axi.bvalid = 0;
  endtask
  task automatic test_reset_mid;
    data_req = 1; data_wr = 0; data_size = 2'b10; data_addr = 32'h80004000;
    step;
    data_req = 0; axi.arready = 1;
    step;
    axi.arready = 0;
    #1;
    checks++; if (axi.rready !== 1'b1) begin errors++; $display("FAIL rm_in_rd_r: got %b want 1", axi.rready); end
    rst = 1;
    step;
    checks++; if ({axi.arvalid, axi.rready, inst_data_ok, data_data_ok} !== 4'b0000) begin errors++; $display("FAIL rm_outputs: got %b want 0000", {axi.arvalid, axi.rready, inst_data_ok, data_data_ok}); end
    checks++; if ({inst_rdata, data_rdata} !== 64'h0) begin errors++; $display("FAIL rm_rdata: got %h %h want 0 0", inst_rdata, data_rdata); end
    rst = 0;
    inst_req = 1; inst_addr = 32'hBFC00008;
    #1;
    checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL rm_idle_accept: got %b want 1", inst_addr_ok); end
    step;
    inst_req = 0;
    #1;
    checks++; if ({axi.arvalid, axi.araddr} !== {1'b1, 32'hBFC00008}) begin errors++; $display("FAIL rm_new_ar: got %b %h want 1 bfc00008", axi.arvalid, axi.araddr); end
    axi.arready = 1;
    step;
    axi.arready = 0; axi.rvalid = 1; axi.rdata = 32'hCAFE0001;
    step;
    axi.rvalid = 0;
  endtask
  initial begin
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rid = 0; axi.rresp = 0; axi.rlast = 1;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bid = 0; axi.bresp = 0;
    test_reset;
    test_inst_read;
    test_byte_store;
    test_simultaneous;
    test_write_order;
    test_half_store;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/sramlike_axi_bridge.md
Name: sramlike_axi_bridge

Overview:
- Sits directly downstream of the CPU top's sram-like inst/data ports and drives one AXI3 master port toward the SoC interconnect.
- Converts each sram-like transaction into a single-beat AXI read or write.
- Serves one transaction at a time; data port has priority over inst port.

Parameters:
- ADDR_W, 32, address width on both sides
- DATA_W, 32, data width; only 32 is supported

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- inst_req / inst_wr  in  1 / 1  inst-side request and write flag (always 0)
- inst_size  in  2  00 byte, 01 half, 10 word
- inst_addr / inst_wdata  in  32 / 32  physical address; write data (unused)
- inst_rdata  out  32  fetched word
- inst_addr_ok / inst_data_ok  out  1 / 1  request accepted; data returned
- data_req, data_wr, data_size, data_addr, data_wdata, data_rdata, data_addr_ok, data_data_ok: same widths and meaning as inst side
- arid, araddr, arsize, arvalid  out  4, 32, 3, 1
- arready  in  1
- rid, rdata, rresp, rlast, rvalid  in  4, 32, 2, 1, 1
- rready  out  1
- awid, awaddr, awsize, awvalid  out  4, 32, 3, 1
- awready  in  1
- wid, wdata, wstrb, wlast, wvalid  out  4, 32, 4, 1, 1
- wready  in  1
- bid, bresp, bvalid  in  4, 2, 1
- bready  out  1
- Tied constants (out): arlen/awlen=0, arburst/awburst=01, arlock/awlock=0, arcache/awcache=0, arprot/awprot=0

Behaviour:
- State machine: IDLE, RD_AR, RD_R, WR_AW_W, WR_B.
- IDLE:
  - If data_req: pulse data_addr_ok for 1 cycle, latch addr/size/wr/wdata, set src=data.
  - Else if inst_req: pulse inst_addr_ok, set src=inst.
  - Next state is RD_AR if wr=0, else WR_AW_W.
  - addr_ok is asserted only in IDLE, combinationally from req. The CPU drops req on the cycle after addr_ok.
- RD_AR:
  - arvalid=1 with latched addr; arsize={1'b0,size}; arid=0 for inst, 1 for data.
  - On arready, go to RD_R.
- RD_R:
  - rready=1.
  - On rvalid: capture rdata into the source's rdata register and pulse that source's data_ok the same cycle (rdata presented combinationally from the bus while rvalid, registered afterwards).
  - Return to IDLE. rresp is ignored.
- WR_AW_W:
  - awvalid and wvalid are raised together; awid=wid=1; wlast=1.
  - aw_done and w_done flags record the handshakes; each may complete in either order or in the same cycle.
  - Each valid drops after its own handshake. Go to WR_B when both are done.
- WR_B:
  - bready=1. On bvalid, pulse data_ok to the source and return to IDLE.
- wstrb rule:
  - size 00 -> 4'b0001 << addr[1:0]
  - size 01 -> 4'b0011 << addr[1:0]
  - size 10 -> 4'b1111
  - wdata is passed unchanged; the CPU has already lane-aligned it.
- Latency: earliest is addr_ok in cycle 0, AR in cycle 1, data_ok in cycle 2.
- Simultaneous inst_req and data_req in IDLE: data wins; inst_addr_ok stays 0 and inst keeps requesting.
- Requests arriving while not in IDLE get no addr_ok.
- Back-to-back requests: returning to IDLE and accepting a new request costs no extra bubble; IDLE is evaluated the cycle after data_ok.
- Reset values: state=IDLE; all valid/ready/ok outputs 0; rdata registers 0; ids 0. Reset mid-transaction forces IDLE immediately. The outstanding AXI transfer is abandoned; the system resets the interconnect together with the CPU.

Decomposition:
- Shared package (e.g. axi_bridge_pkg) holds:
  - the state enum
  - AXI burst/size/id constants (ID_INST=0, ID_DATA=1, BURST_INCR=2'b01)
  - a size-to-wstrb function
- No sub-module is needed. Optionally split a per-source response demux (bridge_resp_demux) routing rdata/data_ok by src.

Test Plan:
- Inst read: inst_req, addr 0xBFC00000, arready after 2 cycles, rdata 0x3C08BFAF -> inst_addr_ok 1 pulse; araddr 0xBFC00000, arid 0, arsize 010; inst_data_ok 1 pulse with inst_rdata=0x3C08BFAF.
- Data byte store: data_req, wr=1, size 00, addr 0x80001003, wdata 0xAB000000 -> awaddr 0x80001003, wstrb 1000, awsize 000; data_data_ok only on bvalid.
- Simultaneous inst_req and data_req (data read 0x80002000) -> data_addr_ok first, inst_addr_ok 0. The inst request is accepted in the IDLE cycle after data_data_ok.
- Write with wready 3 cycles before awready, then awready and wready in the same cycle -> exactly one handshake each; transition to WR_B only after both.
- Halfword store, size 01, addr 0x80000002 -> wstrb 1100.
- Reset asserted in RD_R with rvalid low -> next cycle IDLE; arvalid, rready and both data_ok signals are 0.
